// File: rtl/modeline_ctrl.sv
// Modeline shadow/active register controller: validates a committed modeline,
// waits for vertical blanking (or timeout), applies atomically and resets the sync generator.
module modeline_ctrl #(
  parameter int RST_CYCLES = 8,
  parameter int TIMEOUT    = 1048575
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [3:0]  reg_addr,
  input  logic        reg_wr_en,
  input  logic [11:0] reg_dta_in,
  input  logic        v_blank,
  output logic        syncgen_rst,
  output logic [11:0] horizontal_resolution,
  output logic [11:0] horizontal_sync_start,
  output logic [11:0] horizontal_sync_end,
  output logic [11:0] horizontal_length,
  output logic [11:0] vertical_resolution,
  output logic [11:0] vertical_sync_start,
  output logic [11:0] vertical_sync_end,
  output logic [11:0] horizontal_halfline,
  output logic [11:0] vertical_length,
  output logic        interlaced,
  output logic        pixel_repetition,
  output logic        clip_display_size,
  output logic        busy,
  output logic        cfg_error
);
  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_APPLY = 2'd3;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [19:0]    TMO_LAST = 20'(TIMEOUT - 1);

  // index: 0 hres 1 hss 2 hse 3 hlen 4 vres 5 vss 6 vse 7 halfline 8 vlen 9 mode
  localparam logic [9:0][11:0] DEF = {12'd0, 12'd525, 12'd0, 12'd492, 12'd490,
                                      12'd480, 12'd800, 12'd752, 12'd656, 12'd640};

  logic [1:0]        state;
  logic [RCW-1:0]    rcnt;
  logic [19:0]       tcnt;
  logic              vb_q;
  logic              err;
  logic [9:0][11:0]  sh, act;
  logic              valid, vb_edge, tmo;

  always_comb begin
    valid = (sh[0] <= sh[1]) && (sh[1] < sh[2]) && (sh[2] <= sh[3]) && (sh[3] != 12'd0) &&
            (sh[4] <= sh[5]) && (sh[5] < sh[6]) && (sh[6] <= sh[8]) && (sh[8] != 12'd0) &&
            (!sh[9][0] || (sh[7] < sh[3]));
  end

  assign vb_edge = v_blank & ~vb_q;
  assign tmo     = (tcnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RESET;
      rcnt  <= '0;
      tcnt  <= '0;
      vb_q  <= 1'b0;
      err   <= 1'b0;
      sh    <= DEF;
      act   <= DEF;
    end else if (clk_en) begin
      vb_q <= v_blank;
      case (state)
        S_RESET: begin
          if (rcnt == RST_LAST) begin
            state <= S_IDLE;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (reg_wr_en) begin
            for (int i = 0; i < 9; i++)
              if (reg_addr == 4'(i)) sh[i] <= reg_dta_in;
            if (reg_addr == 4'd9) sh[9] <= {9'd0, reg_dta_in[2:0]};
            if (reg_addr == 4'd15 && reg_dta_in[0]) begin
              if (valid) begin
                err   <= 1'b0;
                tcnt  <= '0;
                state <= S_WAIT;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        S_WAIT: begin
          // edge and timeout together still produce a single apply
          if (vb_edge || tmo) state <= S_APPLY;
          else                tcnt  <= tcnt + 1'b1;
        end
        default: begin
          act   <= sh;
          rcnt  <= '0;
          state <= S_RESET;
        end
      endcase
    end
  end

  assign syncgen_rst           = (state != S_RESET);
  assign busy                  = (state != S_IDLE);
  assign cfg_error             = err;
  assign horizontal_resolution = act[0];
  assign horizontal_sync_start = act[1];
  assign horizontal_sync_end   = act[2];
  assign horizontal_length     = act[3];
  assign vertical_resolution   = act[4];
  assign vertical_sync_start   = act[5];
  assign vertical_sync_end     = act[6];
  assign horizontal_halfline   = act[7];
  assign vertical_length       = act[8];
  assign interlaced            = act[9][0];
  assign pixel_repetition      = act[9][1];
  assign clip_display_size     = act[9][2];
endmodule

// File: tb/tb_modeline_ctrl.sv
// Bench for modeline_ctrl: table of modelines plus randomized commits against a
// transaction-level model of shadow/active sets and apply timing.
module tb_modeline_ctrl;
  localparam int RST = 8;
  localparam int TMO = 100;
  localparam logic [9:0][11:0] DEF = {12'd0, 12'd525, 12'd0, 12'd492, 12'd490,
                                      12'd480, 12'd800, 12'd752, 12'd656, 12'd640};

  logic clk = 0, rst = 0, clk_en = 1, reg_wr_en = 0, v_blank = 0;
  logic [3:0] reg_addr = 0;
  logic [11:0] reg_dta_in = 0;
  logic syncgen_rst, interlaced, pixel_repetition, clip_display_size, busy, cfg_error;
  logic [11:0] hres, hss, hse, hlen, vres, vss, vse, hhl, vlen;
  logic [9:0][11:0] ov, sh_m, act_m;
  int passed = 0, total = 0;

  typedef struct { logic [9:0][11:0] r; bit ok; } vec_t;
  vec_t tbl[8];

  modeline_ctrl #(.RST_CYCLES(RST), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
    .reg_dta_in(reg_dta_in), .v_blank(v_blank), .syncgen_rst(syncgen_rst),
    .horizontal_resolution(hres), .horizontal_sync_start(hss), .horizontal_sync_end(hse),
    .horizontal_length(hlen), .vertical_resolution(vres), .vertical_sync_start(vss),
    .vertical_sync_end(vse), .horizontal_halfline(hhl), .vertical_length(vlen),
    .interlaced(interlaced), .pixel_repetition(pixel_repetition),
    .clip_display_size(clip_display_size), .busy(busy), .cfg_error(cfg_error));

  always #5 clk = ~clk;
  assign ov = {{9'd0, clip_display_size, pixel_repetition, interlaced},
               vlen, hhl, vse, vss, vres, hlen, hse, hss, hres};

  task automatic chk(input string name, input logic [119:0] got, input logic [119:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [9:0][11:0] mk(input int a, b, c, d, e, f, g, h, i, m);
    mk = {12'(m), 12'(i), 12'(h), 12'(g), 12'(f), 12'(e), 12'(d), 12'(c), 12'(b), 12'(a)};
  endfunction

  function automatic bit ok_line(input logic [9:0][11:0] s);
    bit h = s[0] <= s[1] && s[1] < s[2] && s[2] <= s[3] && s[3] != 0;
    bit v = s[4] <= s[5] && s[5] < s[6] && s[6] <= s[8] && s[8] != 0;
    ok_line = h && v && (!s[9][0] || s[7] < s[3]);
  endfunction

  task automatic tick(); @(negedge clk); endtask

  task automatic wr(input int a, input logic [11:0] d, input bit ce);
    reg_addr = 4'(a); reg_dta_in = d; reg_wr_en = 1; clk_en = ce;
    tick();
    reg_wr_en = 0; clk_en = 1;
    if (ce && a < 9) sh_m[a] = d;
    else if (ce && a == 9) sh_m[9] = {9'd0, d[2:0]};
  endtask

  task automatic load(input logic [9:0][11:0] r, input bit drop_some);
    for (int i = 0; i < 10; i++) wr(i, r[i], drop_some ? ($urandom_range(0, 7) != 0) : 1'b1);
  endtask

  // Called right after a passing commit; apply lands ap edges later.
  task automatic run_commit(input int k, input bit use_edge, input bit hold, input bit wr_busy);
    int ap;
    bit stable = 1, low = 1;
    ap = hold ? TMO + 1 : (use_edge ? ((k + 1 < TMO) ? k + 1 : TMO) + 1 : TMO + 1);
    for (int t = 0; t <= ap + RST; t++) begin
      if (t < ap) stable &= (ov === act_m) && busy && syncgen_rst;
      if (t == ap) begin
        chk("apply_values", ov, sh_m);
        chk("apply_rst_low", {119'd0, syncgen_rst}, 120'd0);
        chk("apply_cfg_error", {119'd0, cfg_error}, 120'd0);
      end
      if (t > ap && t < ap + RST) low &= !syncgen_rst;
      if (t == ap + RST) chk("release_idle", {118'd0, syncgen_rst, busy}, 120'd2);
      v_blank = hold ? (t < ap) : (use_edge && t >= k && t < ap);
      reg_wr_en = 0;
      if (wr_busy && t == 1) begin reg_addr = 0; reg_dta_in = 12'd100; reg_wr_en = 1; end
      if (wr_busy && t == 3) begin reg_addr = 15; reg_dta_in = 12'd1; reg_wr_en = 1; end
      if (t < ap + RST) tick();
    end
    reg_wr_en = 0; v_blank = 0;
    chk("pre_apply_stable", {119'd0, stable}, 120'd1);
    chk("rst_pulse_low", {119'd0, low}, 120'd1);
    act_m = sh_m;
  endtask

  task automatic commit(input bit exp_ok, input int k, input bit use_edge, input bit wr_busy);
    wr(15, 12'd1, 1'b1);
    if (exp_ok) run_commit(k, use_edge, 1'b0, wr_busy);
    else chk("reject", {ov, busy, cfg_error, syncgen_rst}, {act_m, 1'b0, 1'b1, 1'b1});
  endtask

  initial begin
    bit low;
    sh_m = DEF; act_m = DEF;
    tbl[0] = '{mk(720, 736, 798, 858, 480, 489, 495, 0, 525, 0), 1};
    tbl[1] = '{mk(640, 900, 752, 800, 480, 490, 492, 0, 525, 0), 0};
    tbl[2] = '{mk(640, 640, 800, 800, 480, 480, 525, 0, 525, 6), 1};
    tbl[3] = '{mk(640, 700, 700, 800, 480, 490, 492, 0, 525, 0), 0};
    tbl[4] = '{mk(640, 656, 752, 800, 480, 490, 492, 800, 525, 1), 0};
    tbl[5] = '{mk(640, 656, 752, 800, 480, 490, 492, 400, 525, 1), 1};
    tbl[6] = '{mk(640, 656, 752, 800, 480, 490, 530, 0, 525, 0), 0};
    tbl[7] = '{mk(640, 656, 752, 800, 480, 490, 492, 900, 525, 2), 1};

    // reset state and release
    repeat (3) tick();
    chk("reset_state", {ov, syncgen_rst, busy, cfg_error}, {DEF, 1'b0, 1'b1, 1'b0});
    rst = 1;
    low = 1;
    for (int i = 0; i < RST; i++) begin low &= !syncgen_rst; tick(); end
    chk("reset_pulse_low", {119'd0, low}, 120'd1);
    chk("reset_release", {ov, syncgen_rst, busy}, {DEF, 1'b1, 1'b0});

    // table: validation rules, boundaries, error set/clear
    for (int i = 0; i < 8; i++) begin
      load(tbl[i].r, 1'b0);
      commit(tbl[i].ok, (i == 0) ? 20 : i, 1'b1, 1'b0);
    end

    // busy freezes shadow; timeout path with v_blank low
    load(mk(800, 816, 900, 1000, 600, 601, 604, 0, 628, 0), 1'b0);
    wr(15, 12'd1, 1'b1);
    run_commit(0, 1'b0, 1'b0, 1'b1);
    chk("frozen_hres", {108'd0, hres}, {108'd0, 12'd800});

    // v_blank already high before entry: no edge, timeout applies
    wr(0, 12'd700, 1'b1);
    v_blank = 1; tick();
    wr(15, 12'd1, 1'b1);
    run_commit(0, 1'b0, 1'b1, 1'b0);

    // clk_en low freezes everything
    clk_en = 0; reg_addr = 15; reg_dta_in = 1; reg_wr_en = 1;
    repeat (4) tick();
    reg_wr_en = 0; clk_en = 1;
    chk("clk_en_hold", {ov, busy, syncgen_rst}, {act_m, 1'b0, 1'b1});

    // randomized modelines and commit timing
    for (int n = 0; n < 30; n++) begin
      logic [9:0][11:0] r;
      int a, b, c, d, e, f, g, h;
      a = $urandom_range(16, 1500); b = a + $urandom_range(0, 40);
      c = b + $urandom_range(1, 100); d = c + $urandom_range(0, 200);
      e = $urandom_range(16, 1000); f = e + $urandom_range(0, 20);
      g = f + $urandom_range(1, 10); h = g + $urandom_range(0, 50);
      r = mk(a, b, c, d, e, f, g, $urandom_range(0, d + 50), h, $urandom_range(0, 7));
      load(r, 1'b1);
      if ($urandom_range(0, 3) == 0) wr($urandom_range(0, 9), 12'($urandom), 1'b1);
      commit(ok_line(sh_m), $urandom_range(0, 130), $urandom_range(0, 3) != 0, 1'b0);
    end

    // reset during WAIT_VB: defaults back, pending commit lost
    load(mk(720, 736, 798, 858, 480, 489, 495, 0, 525, 0), 1'b0);
    wr(15, 12'd1, 1'b1);
    repeat (5) tick();
    rst = 0; tick();
    chk("midrst_state", {ov, syncgen_rst, busy}, {DEF, 1'b0, 1'b1});
    rst = 1;
    repeat (RST + 2) tick();
    v_blank = 1; repeat (3) tick(); v_blank = 0;
    repeat (150) tick();
    chk("midrst_no_apply", {ov, syncgen_rst, busy, cfg_error}, {DEF, 1'b1, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
